// File: rtl/sync_fifo_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ext
//  Description : Single-clock FIFO with internal register storage, level
//                output, almost-full/almost-empty thresholds, sticky
//                overflow/underflow flags and a selectable read mode
//                (registered read or first-word-fall-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ext #(
    parameter int DEPTH     = 32,
    parameter int DATA_W    = 32,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wreq,
    input  logic [DATA_W-1:0] wdata,
    output logic              full_flg,
    output logic              afull_flg,
    input  logic              rreq,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              empty_flg,
    output logic              aempty_flg,
    output logic [LVL_W-1:0]  level,
    output logic              ovf_flg,
    output logic              udf_flg,
    input  logic              clr_err
);

    localparam int               c_PTR_W    = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [LVL_W-1:0] c_LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] c_AFULL    = LVL_W'(AFULL_TH);
    localparam logic [LVL_W-1:0] c_AEMPTY   = LVL_W'(AEMPTY_TH);

    // Elaboration-time sanity checks on the parameter set
    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo_ext: DEPTH must be >= 2");
    end
    if ((AFULL_TH < 0) || (AFULL_TH > DEPTH)) begin : g_chk_afull
        $error("sync_fifo_ext: AFULL_TH must lie in 0..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH)) begin : g_chk_aempty
        $error("sync_fifo_ext: AEMPTY_TH must lie in 0..DEPTH");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_chk_fwft
        $error("sync_fifo_ext: FWFT must be 0 or 1");
    end

    logic [DATA_W-1:0]  r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [c_PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [LVL_W-1:0]   r_level_q, w_level_d;
    logic               r_ovf_q, w_ovf_d;
    logic               r_udf_q, w_udf_d;
    logic               w_wr_acc;
    logic               w_rd_acc;

    // Status flags are pure decodes of the registered level
    assign full_flg   = (r_level_q == c_LVL_FULL);
    assign empty_flg  = (r_level_q == '0);
    assign afull_flg  = (r_level_q >= c_AFULL);
    assign aempty_flg = (r_level_q <= c_AEMPTY);
    assign level      = r_level_q;
    assign ovf_flg    = r_ovf_q;
    assign udf_flg    = r_udf_q;

    // Acceptance, pointer wrap, level update and sticky error next-state
    always_comb begin
        w_wr_acc  = wreq & ~full_flg;
        w_rd_acc  = rreq & ~empty_flg;
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_level_d = r_level_q;

        // Pointers wrap explicitly so non-power-of-two depths work
        if (w_wr_acc) begin
            w_wptr_d = (r_wptr_q == c_PTR_LAST) ? '0 : r_wptr_q + c_PTR_ONE;
        end
        if (w_rd_acc) begin
            w_rptr_d = (r_rptr_q == c_PTR_LAST) ? '0 : r_rptr_q + c_PTR_ONE;
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_d = r_level_q + c_LVL_ONE;
            2'b01:   w_level_d = r_level_q - c_LVL_ONE;
            default: w_level_d = r_level_q;
        endcase

        // A new error in the same cycle as clr_err keeps the flag set
        w_ovf_d = (wreq & full_flg)  | (r_ovf_q & ~clr_err);
        w_udf_d = (rreq & empty_flg) | (r_udf_q & ~clr_err);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_level_q <= '0;
            r_ovf_q   <= 1'b0;
            r_udf_q   <= 1'b0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_level_q <= w_level_d;
            r_ovf_q   <= w_ovf_d;
            r_udf_q   <= w_udf_d;
        end
    end

    // Storage array; contents need no reset, reset only blocks the write
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem_q[r_wptr_q] <= wdata;
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_W-1:0] r_rdata_q, w_rdata_d;
        logic              r_rvalid_q, w_rvalid_d;

        // Load the head word on a pop; otherwise hold data and drop valid
        always_comb begin
            w_rdata_d  = r_rdata_q;
            w_rvalid_d = 1'b0;
            if (w_rd_acc) begin
                w_rdata_d  = r_mem_q[r_rptr_q];
                w_rvalid_d = 1'b1;
            end
        end

        // Registered read-data stage
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rdata_q  <= '0;
                r_rvalid_q <= 1'b0;
            end else begin
                r_rdata_q  <= w_rdata_d;
                r_rvalid_q <= w_rvalid_d;
            end
        end

        assign rdata  = r_rdata_q;
        assign rvalid = r_rvalid_q;
    end else begin : g_fwft_read
        // Head word is presented directly; forced to zero while empty so
        // stale storage never leaks out (and rdata reads 0 after reset)
        assign rvalid = ~empty_flg;
        assign rdata  = empty_flg ? '0 : r_mem_q[r_rptr_q];
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ext.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_ext
//  Description : Scoreboard bench for sync_fifo_ext. Two instances (registered
//                read and FWFT) share one stimulus stream; a queue-based
//                reference model predicts level, flags and read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_ext;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wreq = 1'b0;
    logic          rreq = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic          full0, afull0, empty0, aempty0, rvalid0, ovf0, udf0;
    logic [DW-1:0] rdata0;
    logic [2:0]    level0;
    logic          full1, afull1, empty1, aempty1, rvalid1, ovf1, udf1;
    logic [DW-1:0] rdata1;
    logic [2:0]    level1;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DEPTH(DEPTH), .DATA_W(DW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .full_flg(full0), .afull_flg(afull0),
        .rreq(rreq), .rdata(rdata0), .rvalid(rvalid0), .empty_flg(empty0), .aempty_flg(aempty0),
        .level(level0), .ovf_flg(ovf0), .udf_flg(udf0), .clr_err(clr_err)
    );

    sync_fifo_ext #(.DEPTH(DEPTH), .DATA_W(DW), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .wreq(wreq), .wdata(wdata), .full_flg(full1), .afull_flg(afull1),
        .rreq(rreq), .rdata(rdata1), .rvalid(rvalid1), .empty_flg(empty1), .aempty_flg(aempty1),
        .level(level1), .ovf_flg(ovf1), .udf_flg(udf1), .clr_err(clr_err)
    );

    // Expected state after one clock edge
    typedef struct packed {
        logic [7:0] lvl;
        logic       ovf;
        logic       udf;
        logic       pop;
        logic       rst;
        logic [7:0] hold0;
    } stat_t;

    stat_t         stat_q[$];
    logic [DW-1:0] rd0_q[$];   // words the registered-read DUT must return
    logic [DW-1:0] rd1_q[$];   // words the FWFT DUT must present, in order
    logic [DW-1:0] mdl[$];     // reference FIFO contents
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] m_hold0 = '0;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the predicted outcome
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        stat_t st;
        logic  full, empty, wacc, racc;
        @(negedge clk);
        wreq = w; wdata = d; rreq = r; clr_err = c; rst = rs;
        st = '0;
        if (rs) begin
            mdl.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_hold0 = '0;
            st.rst  = 1'b1;
        end else begin
            full  = (mdl.size() == DEPTH);
            empty = (mdl.size() == 0);
            wacc  = w && !full;
            racc  = r && !empty;
            if (racc) begin
                m_hold0 = mdl.pop_front();
                rd0_q.push_back(m_hold0);
            end
            if (wacc) begin
                mdl.push_back(d);
                rd1_q.push_back(d);
            end
            m_ovf  = (w && full)  || (m_ovf && !c);
            m_udf  = (r && empty) || (m_udf && !c);
            st.pop = racc;
        end
        st.lvl   = 8'(mdl.size());
        st.ovf   = m_ovf;
        st.udf   = m_udf;
        st.hold0 = m_hold0;
        stat_q.push_back(st);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected status per edge, compared 1 time unit after it
    initial begin : mon
        stat_t         st;
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (stat_q.size() > 0) begin
                st = stat_q.pop_front();
                chk8("level0", 8'(level0), st.lvl);
                chk8("level1", 8'(level1), st.lvl);
                chk1("full", full0, st.lvl == DEPTH);
                chk1("afull", afull0, st.lvl >= AF);
                chk1("empty", empty0, st.lvl == 0);
                chk1("aempty", aempty0, st.lvl <= AE);
                chk1("full1", full1, st.lvl == DEPTH);
                chk1("empty1", empty1, st.lvl == 0);
                chk1("ovf", ovf0, st.ovf);
                chk1("udf", udf0, st.udf);
                chk1("ovf1", ovf1, st.ovf);
                chk1("udf1", udf1, st.udf);
                // registered read path
                if (st.rst) rd0_q.delete();
                chk1("rvalid0", rvalid0, st.pop);
                if (st.pop) begin
                    if (rd0_q.size() == 0) begin
                        chk1("rd0_queue_nonempty", 1'b0, 1'b1);
                    end else begin
                        e = rd0_q.pop_front();
                        chk8("rdata0", rdata0, e);
                    end
                end else begin
                    chk8("rdata0_hold", rdata0, st.hold0);
                end
                // first-word-fall-through path
                if (st.rst) begin
                    rd1_q.delete();
                    chk8("rdata1_rst", rdata1, 8'h00);
                end else if (st.pop && rd1_q.size() > 0) begin
                    void'(rd1_q.pop_front());
                end
                chk1("rvalid1", rvalid1, st.lvl != 0);
                if (st.lvl != 0 && rd1_q.size() > 0) chk8("rdata1", rdata1, rd1_q[0]);
            end
        end
    end

    initial begin : drv
        logic [7:0] fill_v[4];
        fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;

        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        settle();
        chk1("rst_empty", empty0, 1'b1);
        chk1("rst_afull", afull0, 1'b0);

        // fill then drain with the registered read path
        for (int i = 0; i < 4; i++) step(1, fill_v[i], 0, 0, 0);
        settle();
        chk1("fill_full", full0, 1'b1);
        chk8("fill_level", 8'(level0), 8'd4);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        settle();
        chk1("drain_empty", empty0, 1'b1);
        chk8("drain_last", rdata0, 8'h44);

        // overflow on a full FIFO, then clear
        for (int i = 0; i < 4; i++) step(1, 8'h61 + 8'(i), 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        settle();
        chk1("ovf_set", ovf0, 1'b1);
        chk8("ovf_level", 8'(level0), 8'd4);
        step(0, 8'h00, 0, 1, 0);
        settle();
        chk1("ovf_clr", ovf0, 1'b0);

        // full with write+pop: pop accepted, write dropped
        step(1, 8'h77, 1, 0, 0);
        settle();
        chk8("fullsim_level", 8'(level0), 8'd3);
        chk1("fullsim_ovf", ovf0, 1'b1);
        chk8("fullsim_head", rdata0, 8'h61);
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);

        // empty with write+pop: write accepted, underflow flagged
        step(1, 8'hA5, 1, 0, 0);
        settle();
        chk8("emptysim_level", 8'(level1), 8'd1);
        chk1("emptysim_udf", udf1, 1'b1);
        chk1("emptysim_rvalid", rvalid1, 1'b1);
        chk8("emptysim_rdata", rdata1, 8'hA5);
        step(0, 8'h00, 0, 1, 0);

        // level 1 write+pop in FWFT mode keeps rvalid high
        step(1, 8'h5A, 1, 0, 0);
        settle();
        chk1("l1sim_rvalid", rvalid1, 1'b1);
        chk8("l1sim_rdata", rdata1, 8'h5A);

        // wrap at level 2, then cross the almost-full threshold
        step(1, 8'h01, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 8'h80 + 8'(i), 1, 0, 0);
        settle();
        chk8("wrap_level", 8'(level0), 8'd2);
        chk1("wrap_aempty", aempty0, 1'b0);
        chk1("wrap_afull", afull0, 1'b0);
        step(1, 8'hEE, 0, 0, 0);
        settle();
        chk1("wrap_afull_set", afull0, 1'b1);

        // reset mid-stream with a write pending
        step(1, 8'h99, 0, 0, 1);
        settle();
        chk8("midrst_level", 8'(level0), 8'd0);
        chk1("midrst_empty", empty0, 1'b1);
        chk1("midrst_rvalid", rvalid0, 1'b0);
        chk8("midrst_rdata", rdata0, 8'h00);

        // underflow together with clr_err: the set wins
        step(0, 8'h00, 1, 1, 0);
        settle();
        chk1("setwins_udf", udf0, 1'b1);
        step(0, 8'h00, 0, 1, 0);

        // randomized traffic, alternating fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (((i / 40) % 2) != 0) ? 30 : 75;
            step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0);
        end

        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 The block SHALL have these parameters:
- DEPTH, default 32, number of entries (any integer >= 2; power of two not required).
- DATA_W, default 32, data width in bits.
- AFULL_TH, default DEPTH-2, almost-full threshold in entries.
- AEMPTY_TH, default 2, almost-empty threshold in entries.
- FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; one clock; all logic rising-edge.
- rst, in, 1, reset; synchronous and active-high.
- wreq, in, 1, write request.
- wdata, in, DATA_W, write data.
- full_flg, out, 1, FIFO holds DEPTH entries.
- afull_flg, out, 1, level >= AFULL_TH.
- rreq, in, 1, read request.
- rdata, out, DATA_W, read data.
- rvalid, out, 1, rdata holds valid data.
- empty_flg, out, 1, FIFO holds 0 entries.
- aempty_flg, out, 1, level <= AEMPTY_TH.
- level, out, LVL_W = clog2(DEPTH+1), current entry count.
- ovf_flg, out, 1, sticky write-overflow flag.
- udf_flg, out, 1, sticky read-underflow flag.
- clr_err, in, 1, clears ovf_flg and udf_flg.

Function
REQ-003 Storage SHALL be an internal DEPTH x DATA_W register array; no external RAM instance.
REQ-004 Write and read pointers SHALL be clog2(DEPTH) wide and wrap from DEPTH-1 to 0 explicitly, with no reliance on natural binary overflow.
REQ-005 All DEPTH entries SHALL be usable; full and empty SHALL be derived from level, not from pointer comparison.
REQ-006 A write SHALL be accepted when wreq=1 and full_flg=0 at the clock edge.
REQ-007 An accepted write SHALL store wdata at the write pointer and advance the pointer.
REQ-008 A pop SHALL be accepted when rreq=1 and empty_flg=0 at the clock edge; an accepted pop advances the read pointer.
REQ-009 Level SHALL update as follows: write only +1, pop only -1, both accepted unchanged, neither unchanged.
REQ-010 Level SHALL never exceed DEPTH and never go below 0.
REQ-011 full_flg, empty_flg, afull_flg and aempty_flg SHALL be combinational decodes of the registered level and SHALL be valid in the cycle after the causing edge.
REQ-012 Full with wreq=1 and rreq=1: the pop SHALL be accepted, the write SHALL be dropped, and ovf_flg SHALL set, because acceptance is based on the pre-edge full_flg.
REQ-013 Empty with wreq=1 and rreq=1: the write SHALL be accepted, no pop occurs, and udf_flg SHALL set.
REQ-014 ovf_flg SHALL set on wreq=1 & full_flg=1; udf_flg SHALL set on rreq=1 & empty_flg=1; both SHALL hold until clr_err=1 or rst.
REQ-015 If clr_err=1 and a new error occur in the same cycle, the set SHALL win.
REQ-016 FWFT=0 read path:
- On an accepted pop, rdata SHALL be loaded with mem[rptr] and rvalid SHALL be 1 on the following cycle (1-cycle latency).
- Otherwise rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-017 FWFT=1 read path:
- rdata SHALL equal mem[rptr] whenever empty_flg=0, and rvalid SHALL equal ~empty_flg.
- rreq acts as acknowledge of the presented word; the next word appears the cycle after the pop.
- A word written into an empty FIFO SHALL be visible on rdata/rvalid the cycle after the write edge.
REQ-018 With FWFT=1 and level=1, simultaneous write+pop SHALL present the new word the next cycle with rvalid held at 1.
REQ-019 Thresholds outside 0..DEPTH SHALL be rejected by an elaboration-time check.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL clear pointers and level to 0, and set rdata=0, rvalid=0, ovf_flg=0 and udf_flg=0.
REQ-021 After reset, empty_flg=1, aempty_flg=1, full_flg=0, afull_flg=0 (for AFULL_TH>0).
REQ-022 rst asserted mid-operation SHALL discard all contents and override all same-cycle wreq, rreq and clr_err.
REQ-023 Memory contents SHALL NOT need reset.

Verification (DEPTH=4, DATA_W=8, AFULL_TH=3, AEMPTY_TH=1)
REQ-024 Fill/drain, FWFT=0: write 0x11, 0x22, 0x33, 0x44 -> full_flg=1 and level=4 after the 4th edge; 4 pops -> rdata 0x11..0x44 each 1 cycle after its pop with rvalid=1; then empty_flg=1.
REQ-025 Overflow: on a full FIFO, wreq=1 with 0x55 and rreq=0 -> level stays 4, ovf_flg=1; pulse clr_err -> ovf_flg=0.
REQ-026 Full simultaneous: full FIFO, wreq+rreq -> pop of head, write dropped, level=3, ovf_flg=1.
REQ-027 Empty simultaneous, FWFT=1: wreq=1 with 0xA5 plus rreq=1 on empty -> level=1, udf_flg=1, next cycle rdata=0xA5 and rvalid=1.
REQ-028 Thresholds and wrap: run 10 write/pop pairs at level 2 -> pointers wrap, level stays 2, aempty_flg=0, afull_flg=0; one more write -> afull_flg=1.
REQ-029 Reset mid-stream: assert rst at level 3 with wreq=1 -> next cycle level=0, empty_flg=1, rvalid=0, rdata=0.
